// File: rtl/pulse_burst_ctrl_pkg.sv
// Shared definitions for the pulse burst controller: FSM state codes and
// configuration register addresses.
package pulse_burst_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DELAY = 2'd1;
  localparam state_t ST_HIGH  = 2'd2;
  localparam state_t ST_LOW   = 2'd3;

  localparam logic [1:0] ADDR_DELAY  = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_WIDTH  = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

endpackage

// File: rtl/pulse_burst_ctrl_phase_cnt.sv
// Loadable down-counter that times one phase of the burst. A phase loaded
// with value L lasts L+1 cycles: the zero flag is raised in its last cycle.
module phase_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Load has priority; decrement stops at zero so the flag stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_burst_ctrl.sv
// Pulse burst controller: after a start request emits a delay, then a train
// of pulses with programmable width and period, optionally bounded in count.
module pulse_burst_ctrl
  import pulse_burst_ctrl_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int DEF_DELAY  = 10,
  parameter int DEF_PERIOD = 100,
  parameter int DEF_WIDTH  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic             out,
  output logic [CNT_W-1:0] pulse_cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + ONE;
  endfunction

  logic [CNT_W-1:0] delay_r, period_r, width_r, count_r;
  logic [CNT_W-1:0] wload_wk, lload_wk, count_wk;
  logic [CNT_W-1:0] w_eff, wload_cfg, lload_cfg;

  state_t           state, state_n;
  logic             out_n, done_n;
  logic             ld, dec, accept, inc, zero;
  logic [CNT_W-1:0] ld_val;

  // Width 0 behaves as 1; a period not longer than the width leaves a single
  // LOW cycle. The LOW length is formed as period-width so nothing overflows.
  assign w_eff     = (width_r == '0) ? ONE : width_r;
  assign wload_cfg = w_eff - ONE;
  assign lload_cfg = (period_r > w_eff) ? (period_r - w_eff - ONE) : '0;

  // Configuration registers; writes are locked out for the whole burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_r  <= CNT_W'(DEF_DELAY);
      period_r <= CNT_W'(DEF_PERIOD);
      width_r  <= CNT_W'(DEF_WIDTH);
      count_r  <= '0;
    end else if (cfg_we && !busy) begin
      case (cfg_addr)
        ADDR_DELAY:  delay_r  <= cfg_wdata;
        ADDR_PERIOD: period_r <= cfg_wdata;
        ADDR_WIDTH:  width_r  <= cfg_wdata;
        default:     count_r  <= cfg_wdata;
      endcase
    end
  end

  // Working copies of the phase lengths, frozen at burst acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      wload_wk <= wload_cfg;
      lload_wk <= lload_cfg;
      count_wk <= count_r;
    end
  end

  // Next-state decode; an abort overrides every other transition.
  always_comb begin
    state_n = state;
    out_n   = 1'b0;
    done_n  = 1'b0;
    ld      = 1'b0;
    ld_val  = '0;
    dec     = 1'b0;
    accept  = 1'b0;
    inc     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          accept = 1'b1;
          ld     = 1'b1;
          if (delay_r == '0) begin
            state_n = ST_HIGH;
            out_n   = 1'b1;
            ld_val  = wload_cfg;
            inc     = 1'b1;
          end else begin
            state_n = ST_DELAY;
            ld_val  = delay_r - ONE;
          end
        end
      end
      ST_DELAY, ST_LOW: begin
        if (zero) begin
          state_n = ST_HIGH;
          out_n   = 1'b1;
          ld      = 1'b1;
          ld_val  = wload_wk;
          inc     = 1'b1;
        end else begin
          dec = 1'b1;
        end
      end
      ST_HIGH: begin
        if (zero) begin
          if ((count_wk != '0) && (pulse_cnt == count_wk)) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_LOW;
            ld      = 1'b1;
            ld_val  = lload_wk;
          end
        end else begin
          out_n = 1'b1;
          dec   = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (stop && (state != ST_IDLE)) begin
      state_n = ST_IDLE;
      out_n   = 1'b0;
      done_n  = 1'b0;
      ld      = 1'b0;
      dec     = 1'b0;
      inc     = 1'b0;
    end
  end

  // Registered FSM state and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      out   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      out   <= out_n;
      busy  <= (state_n != ST_IDLE);
      done  <= done_n;
    end
  end

  // Pulse counter: cleared on acceptance (or set to 1 when the first pulse
  // starts immediately), then bumped on every rising edge of out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_cnt <= '0;
    end else if (accept) begin
      pulse_cnt <= inc ? ONE : '0;
    end else if (inc) begin
      pulse_cnt <= sat_inc(pulse_cnt);
    end
  end

  phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .dec      (dec),
    .load_val (ld_val),
    .zero     (zero)
  );

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Bench for pulse_burst_ctrl: directed vector table, hand-written corner
// sequences and a randomized run against a cycle-index reference model.
module tb_pulse_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [15:0] cfg_wdata = 16'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, done, out;
  logic [15:0] pulse_cnt;

  int errors = 0;
  int checks = 0;

  pulse_burst_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .stop(stop), .busy(busy),
    .done(done), .out(out), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          setc;
    logic [15:0] d, p, w, n;
    bit          st, sp;
    bit          eo, eb, ed;
    logic [15:0] ep;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(bit setc, int d, int p, int w, int n, bit st, bit sp,
                              bit eo, bit eb, bit ed, int ep);
    vec_t v;
    v.setc = setc; v.d = 16'(d); v.p = 16'(p); v.w = 16'(w); v.n = 16'(n);
    v.st = st; v.sp = sp; v.eo = eo; v.eb = eb; v.ed = ed; v.ep = 16'(ep);
    return v;
  endfunction

  function automatic logic [31:0] pack(logic o, logic b, logic d, logic [15:0] p);
    return {13'd0, o, b, d, p};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [1:0] a, logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // Start a burst with default settings and check the first two pulses.
  task automatic default_timing(string tag);
    bit ob[113];
    int first, ones;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 112; c++) begin
      ob[c] = out;
      if (c < 112) tick();
    end
    first = -1; ones = 0;
    for (int c = 1; c <= 110; c++) begin
      if (ob[c] && first < 0) first = c;
      if (ob[c]) ones++;
    end
    chk({tag, "_first_rise"}, 32'(first), 32'd11);
    chk({tag, "_high_len"}, {30'd0, ob[12], ob[13]}, 32'b10);
    chk({tag, "_ones_to_110"}, 32'(ones), 32'd2);
    chk({tag, "_second_rise"}, pack(ob[111], busy, done, pulse_cnt), pack(1, 1, 0, 2));
    stop = 1'b1; tick(); stop = 1'b0;
    chk({tag, "_stop"}, pack(out, busy, done, pulse_cnt), pack(0, 0, 0, 2));
  endtask

  // Reference model: waveform derived from the cycle index since acceptance.
  longint m_reg[4];
  bit     m_act;
  longint m_k, m_d, m_p, m_w, m_n, m_end, m_pc;
  logic   eo, eb, ed;
  logic [15:0] ep;

  function automatic void m_reset();
    m_reg[0] = 10; m_reg[1] = 100; m_reg[2] = 2; m_reg[3] = 0;
    m_act = 0; m_pc = 0; eo = 0; eb = 0; ed = 0; ep = 0;
  endfunction

  function automatic void m_eval();
    longint t;
    if (m_k <= m_d) begin
      eo = 0; m_pc = 0;
    end else begin
      t = m_k - m_d - 1;
      eo = ((t % m_p) < m_w);
      m_pc = t / m_p + 1;
      if (m_pc > 65535) m_pc = 65535;
    end
    ep = 16'(m_pc); eb = 1;
  endfunction

  function automatic void m_edge(bit st, bit sp, bit we, logic [1:0] a, logic [15:0] wd);
    bit was;
    was = m_act;
    ed = 0;
    if (m_act) begin
      if (sp) begin
        m_act = 0; eo = 0; eb = 0;
      end else if (m_n != 0 && m_k == m_end) begin
        m_act = 0; eo = 0; eb = 0; ed = 1;
      end else begin
        m_k++; m_eval();
      end
    end else if (st && !sp) begin
      m_d = m_reg[0];
      m_w = (m_reg[2] == 0) ? 1 : m_reg[2];
      m_p = (m_reg[1] <= m_w) ? m_w + 1 : m_reg[1];
      m_n = m_reg[3];
      m_end = m_d + (m_n - 1) * m_p + m_w;
      m_k = 1; m_act = 1; m_eval();
    end
    if (we && !was) m_reg[a] = longint'(wd);
  endfunction

  initial begin
    vt[0]  = mk(1, 0, 4, 1, 3, 1, 0, 1, 1, 0, 1);
    vt[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vt[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vt[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2);
    vt[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
    vt[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
    vt[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
    vt[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3);
    vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    vt[11] = mk(1, 0, 4, 3, 0, 1, 0, 1, 1, 0, 1);
    vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    vt[13] = mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1);
    vt[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    vt[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2);
    vt[16] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2);
    vt[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

    // Asynchronous reset state.
    #2 rst = 1'b1;
    #1 chk("reset_state", pack(out, busy, done, pulse_cnt), pack(0, 0, 0, 0));
    tick(); rst = 1'b0; tick();

    default_timing("dflt");

    // Directed vector table.
    for (int i = 0; i < 18; i++) begin
      if (vt[i].setc) begin
        wr(2'd0, vt[i].d); wr(2'd1, vt[i].p); wr(2'd2, vt[i].w); wr(2'd3, vt[i].n);
      end
      start = vt[i].st; stop = vt[i].sp;
      tick();
      start = 1'b0; stop = 1'b0;
      chk($sformatf("vec%0d", i), pack(out, busy, done, pulse_cnt),
          pack(vt[i].eo, vt[i].eb, vt[i].ed, vt[i].ep));
    end

    // Width longer than period: high 5, low 1, two pulses.
    begin
      logic [11:0] exp36;
      logic [11:0] got36;
      exp36 = 12'b111110111110;
      wr(2'd0, 16'd1); wr(2'd1, 16'd3); wr(2'd2, 16'd5); wr(2'd3, 16'd2);
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 12; c++) begin
        got36[c] = out;
        tick();
      end
      chk("wide_pattern", 32'(got36), 32'(exp36));
      chk("wide_done", pack(out, busy, done, pulse_cnt), pack(0, 0, 1, 2));
    end

    // start+stop together, then a period write during a burst is ignored.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", pack(out, busy, done, pulse_cnt), pack(0, 0, 0, 2));
    wr(2'd0, 16'd0); wr(2'd1, 16'd4); wr(2'd2, 16'd1); wr(2'd3, 16'd0);
    for (int b = 0; b < 2; b++) begin
      start = 1'b1; tick(); start = 1'b0;
      chk($sformatf("lock_c1_b%0d", b), 32'(out), 32'd1);
      if (b == 0) begin
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 16'd10;
      end
      tick(); cfg_we = 1'b0;
      tick(); tick(); tick();
      chk($sformatf("lock_c5_b%0d", b), pack(out, busy, done, pulse_cnt), pack(1, 1, 0, 2));
      stop = 1'b1; tick(); stop = 1'b0;
      chk($sformatf("lock_stop_b%0d", b), 32'(busy), 32'd0);
    end

    // Reset in the middle of a LOW phase, then default timing is restored.
    start = 1'b1; tick(); start = 1'b0; tick();
    #3 rst = 1'b1;
    #1 chk("rst_mid_low", pack(out, busy, done, pulse_cnt), pack(0, 0, 0, 0));
    tick(); tick(); rst = 1'b0; tick();
    chk("after_rst_idle", pack(out, busy, done, pulse_cnt), pack(0, 0, 0, 0));
    default_timing("rst_dflt");

    // Randomized run against the reference model.
    rst = 1'b1; tick(); rst = 1'b0;
    m_reset();
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 40) == 0);
      cfg_we = ($urandom_range(0, 5) == 0);
      cfg_addr = 2'($urandom_range(0, 3));
      case (cfg_addr)
        2'd0: cfg_wdata = 16'($urandom_range(0, 5));
        2'd1: cfg_wdata = 16'($urandom_range(0, 8));
        2'd2: cfg_wdata = 16'($urandom_range(0, 4));
        default: cfg_wdata = 16'($urandom_range(0, 4));
      endcase
      m_edge(start, stop, cfg_we, cfg_addr, cfg_wdata);
      tick();
      chk($sformatf("rand_c%0d", c), pack(out, busy, done, pulse_cnt), pack(eo, eb, ed, ep));
    end
    start = 1'b0; stop = 1'b0; cfg_we = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
